// File: rtl/fifo_word_unloader.sv
// Pops 32-bit words from a synchronous FIFO and streams them out as BWIDTH-bit chunks,
// most-significant chunk first, on a valid/ready interface.
module fifo_word_unloader #(
  parameter int FWIDTH = 32,
  parameter int BWIDTH = 8,
  parameter int CWIDTH = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              En,
  input  logic [FWIDTH-1:0] F_Data,
  input  logic              F_EmptyN,
  output logic              FOutN,
  output logic [BWIDTH-1:0] Chunk_Out,
  output logic              Chunk_Valid,
  input  logic              Chunk_Ready,
  output logic              Word_Last,
  output logic              Busy,
  output logic [CWIDTH-1:0] Word_Count
);

  localparam int NCHUNK = FWIDTH / BWIDTH;
  localparam int IWIDTH = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IWIDTH-1:0] LASTIDX = IWIDTH'(NCHUNK - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t              state_r, stateNext_s;
  logic [FWIDTH-1:0]   shReg_r, shRegNext_s;
  logic [IWIDTH-1:0]   idx_r, idxNext_s;
  logic [CWIDTH-1:0]   wordCount_r, wordCountNext_s;
  logic                accept_s;
  logic                lastAccept_s;
  logic                pop_s;

  // Handshake and pop decode; a pop may coincide with acceptance of the last chunk.
  always_comb begin
    accept_s     = (state_r == SHIFT) & Chunk_Ready;
    lastAccept_s = accept_s & (idx_r == LASTIDX);
    pop_s        = ~Rst & En & F_EmptyN & ((state_r == IDLE) | lastAccept_s);
  end

  // Next-state logic for the FSM, shift register, chunk index and word counter.
  always_comb begin
    stateNext_s     = state_r;
    shRegNext_s     = shReg_r;
    idxNext_s       = idx_r;
    wordCountNext_s = wordCount_r;
    case (state_r)
      IDLE: begin
        if (pop_s) begin
          shRegNext_s = F_Data;
          idxNext_s   = {IWIDTH{1'b0}};
          stateNext_s = SHIFT;
        end else begin
          stateNext_s = IDLE;
        end
      end
      SHIFT: begin
        if (lastAccept_s) begin
          wordCountNext_s = wordCount_r + CWIDTH'(1);
          if (pop_s) begin
            shRegNext_s = F_Data;
            idxNext_s   = {IWIDTH{1'b0}};
            stateNext_s = SHIFT;
          end else begin
            stateNext_s = IDLE;
          end
        end else if (accept_s) begin
          shRegNext_s = shReg_r << BWIDTH;
          idxNext_s   = idx_r + IWIDTH'(1);
        end else begin
          stateNext_s = SHIFT;
        end
      end
      default: begin
        stateNext_s = IDLE;
        idxNext_s   = {IWIDTH{1'b0}};
      end
    endcase
  end

  // State registers with synchronous reset; a reset discards any word in flight.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r     <= IDLE;
      shReg_r     <= {FWIDTH{1'b0}};
      idx_r       <= {IWIDTH{1'b0}};
      wordCount_r <= {CWIDTH{1'b0}};
    end else begin
      state_r     <= stateNext_s;
      shReg_r     <= shRegNext_s;
      idx_r       <= idxNext_s;
      wordCount_r <= wordCountNext_s;
    end
  end

  assign FOutN       = ~pop_s;
  assign Chunk_Valid = (state_r == SHIFT);
  assign Busy        = (state_r == SHIFT);
  assign Chunk_Out   = (state_r == SHIFT) ? shReg_r[FWIDTH-1 -: BWIDTH] : {BWIDTH{1'b0}};
  assign Word_Last   = (state_r == SHIFT) & (idx_r == LASTIDX);
  assign Word_Count  = wordCount_r;

endmodule
